run_pattern_gen: RTL and testbench

- Transmit-side companion to the team's serial run-length detector.
- Accepts queued run commands {bit value, run length} over a valid/ready handshake and serialises them onto a one-bit line w, one bit per clk, for the detector to sample.
- Runs an internal registered model of the detector, so q_exp gives the detector output expected for the w it produces. Benches and self-test logic compare q_exp against the real detector's q.

---
 rtl/run_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_run_pattern_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/run_pattern_gen.sv
// Serial run pattern generator: queues {bit, length} run commands and plays
// them onto the one-bit line w, back to back. It also carries a registered
// model of the run-length detector, so q_exp is the detector output that
// this w should produce.
module run_pattern_gen #(
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int RUN_THRESH = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             w,
  output logic             run_done,
  output logic             busy,
  output logic             q_exp
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(RUN_THRESH + 1);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(RUN_THRESH);

  typedef enum logic {IDLE, SEND} state_t;

  // Command FIFO. The pointers carry one extra wrap bit to tell full from empty.
  logic             fifo_bit [FIFO_DEPTH];
  logic [LEN_W-1:0] fifo_len [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic             head_bit;
  logic [LEN_W-1:0] head_len;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             w_d;

  // Detector model
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_w_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  // A zero-length command completes the handshake but never occupies the FIFO.
  assign push       = cmd_valid && cmd_ready && (cmd_len != '0);
  assign head_bit   = fifo_bit[rd_ptr[AW-1:0]];
  assign head_len   = fifo_len[rd_ptr[AW-1:0]];

  assign run_done   = (state_q == SEND) && (rem_q == '0);
  assign busy       = (state_q == SEND) || !fifo_empty;

  // FIFO storage: data only, no reset needed since the pointers gate it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_bit[wr_ptr[AW-1:0]] <= cmd_bit;
      fifo_len[wr_ptr[AW-1:0]] <= cmd_len;
    end
  end

  // FIFO pointers: push and pop in the same cycle are both honoured.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Next-state logic: load a new run from the FIFO head whenever the line is free.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    w_d     = w;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
          w_d     = head_bit;
          rem_d   = head_len - LEN_W'(1);
        end
      end
      SEND: begin
        if (rem_q != '0) begin
          rem_d = rem_q - LEN_W'(1);
        end else if (!fifo_empty) begin
          // Seamless hand-over to the next run, even if its bit matches.
          pop   = 1'b1;
          w_d   = head_bit;
          rem_d = head_len - LEN_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; w holds its value whenever no run is loaded.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      w       <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      w       <= w_d;
    end
  end

  // Detector model next count: restart on a new value, saturate at the threshold.
  always_comb begin
    cnt_d = cnt_q;
    if ((cnt_q == '0) || (w != last_w_q))
      cnt_d = CNT_W'(1);
    else if (cnt_q < THRESH)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Detector model registers, sampling the current w every cycle.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt_q    <= '0;
      last_w_q <= 1'b0;
      q_exp    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      last_w_q <= w;
      q_exp    <= (cnt_d == THRESH);
    end
  end

endmodule

// File: tb/tb_run_pattern_gen.sv
// Directed bench for run_pattern_gen: hand-derived w / run_done / busy /
// cmd_ready sequences, plus a small detector model fed from the expected w.
module tb_run_pattern_gen;

  localparam int LEN_W      = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int RUN_THRESH = 4;

  logic             clk = 1'b0;
  logic             Reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_bit;
  logic [LEN_W-1:0] cmd_len;
  logic             w;
  logic             run_done;
  logic             busy;
  logic             q_exp;

  int n_checks = 0;
  int n_errors = 0;

  // expected line value and the detector model driven by it
  logic exp_w = 1'b0;
  int   mcnt  = 0;
  logic mlast = 1'b0;
  logic mq    = 1'b0;

  run_pattern_gen #(
    .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH), .RUN_THRESH(RUN_THRESH)
  ) dut (
    .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bit(cmd_bit), .cmd_len(cmd_len), .w(w), .run_done(run_done),
    .busy(busy), .q_exp(q_exp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the pre-edge expected w, then check all outputs.
  task automatic cycle(input logic ew, input logic erd, input logic ebusy,
                       input logic erdy, input string tag);
    @(posedge clk);
    if (Reset) begin
      mcnt = 0; mlast = 1'b0; mq = 1'b0;
    end else begin
      if (mcnt == 0 || exp_w != mlast) begin
        mcnt = 1; mlast = exp_w;
      end else if (mcnt < RUN_THRESH) begin
        mcnt++;
      end
      mq = (mcnt == RUN_THRESH);
    end
    #1;
    exp_w = ew;
    check({tag, ".w"},         w,         ew);
    check({tag, ".run_done"},  run_done,  erd);
    check({tag, ".busy"},      busy,      ebusy);
    check({tag, ".cmd_ready"}, cmd_ready, erdy);
    check({tag, ".q_exp"},     q_exp,     mq);
  endtask

  initial begin
    Reset = 1'b1; cmd_valid = 1'b0; cmd_bit = 1'b0; cmd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.w", w, 0);
    check("rst.q_exp", q_exp, 0);
    check("rst.run_done", run_done, 0);
    check("rst.busy", busy, 0);
    check("rst.cmd_ready", cmd_ready, 1);
    Reset = 1'b0;

    // {0,5}: pushed at edge 1, on w for edges 2..6, done flagged after edge 6
    cmd_valid = 1'b1; cmd_bit = 1'b0; cmd_len = 4'd5;
    cycle(0, 0, 1, 1, "t1_push");
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, "t1_run");
    cycle(0, 1, 1, 1, "t1_last");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, "t1_idle");

    // {1,3},{0,2},{1,4} back to back: 1,1,1,0,0,1,1,1,1 with no gaps
    cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 4'd3;
    cycle(0, 0, 1, 1, "t2_a");
    cmd_bit = 1'b0; cmd_len = 4'd2;
    cycle(1, 0, 1, 1, "t2_b");
    cmd_bit = 1'b1; cmd_len = 4'd4;
    cycle(1, 0, 1, 0, "t2_c");
    cmd_valid = 1'b0;
    cycle(1, 1, 1, 0, "t2_d");
    cycle(0, 0, 1, 1, "t2_e");
    cycle(0, 1, 1, 1, "t2_f");
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, "t2_g");
    cycle(1, 1, 1, 1, "t2_j");
    cycle(1, 0, 0, 1, "t2_idle");

    // {1,0}: accepted, produces nothing
    cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 4'd0;
    cycle(1, 0, 0, 1, "t3_null");
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, "t3_after");

    // {1,15}: maximum run, then IDLE with w and q_exp held
    cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 4'd15;
    cycle(1, 0, 1, 1, "t4_push");
    cmd_valid = 1'b0;
    for (int i = 0; i < 14; i++) cycle(1, 0, 1, 1, "t4_run");
    cycle(1, 1, 1, 1, "t4_last");
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, "t4_idle");

    // {1,6} with {0,3} queued, Reset asserted in the 3rd cycle of the run
    cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 4'd6;
    cycle(1, 0, 1, 1, "t5_push");
    cmd_bit = 1'b0; cmd_len = 4'd3;
    cycle(1, 0, 1, 1, "t5_c1");
    cmd_valid = 1'b0;
    cycle(1, 0, 1, 1, "t5_c2");
    cycle(1, 0, 1, 1, "t5_c3");
    Reset = 1'b1;
    #1;
    mcnt = 0; mlast = 1'b0; mq = 1'b0; exp_w = 1'b0;
    check("t5_async.w", w, 0);
    check("t5_async.q_exp", q_exp, 0);
    check("t5_async.busy", busy, 0);
    check("t5_async.cmd_ready", cmd_ready, 1);
    check("t5_async.run_done", run_done, 0);
    cycle(0, 0, 0, 1, "t5_held");
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, "t5_post");

    // fresh {1,2} after reset plays normally
    cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 4'd2;
    cycle(0, 0, 1, 1, "t6_push");
    cmd_valid = 1'b0;
    cycle(1, 0, 1, 1, "t6_run");
    cycle(1, 1, 1, 1, "t6_last");
    cycle(1, 0, 0, 1, "t6_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
